// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   state_t   : receiver FSM state encoding (3 bits with the PARITY state,
//               2 bits without it)
//   MID_START : tick count at the middle of the start bit
//   BIT_TICKS : oversample ticks per bit
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_pkg;
  localparam int MID_START = 7;
  localparam int BIT_TICKS = 16;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for asynchronous single-bit inputs.
// Both flops reset to 1, which is the idle level of a UART line and of
// pulled-up button inputs.
//   clk_100MHz : system clock
//   reset      : synchronous, active-high
//   d          : asynchronous input
//   q          : synchronized output (2 clocks of latency)
module sync_2ff (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receiver. Frame is one start bit,
// DBITS data bits LSB first, an optional even-parity bit, then a stop bit
// lasting SB_TICK ticks.
//   clk_100MHz   : system clock
//   reset        : synchronous, active-high; abandons any frame in progress
//   rx           : asynchronous serial line, idles high
//   tick         : 16x oversample strobe, one clock wide
//   data_ready   : one-clock pulse when a frame completes (good or bad)
//   data_out     : last received word, held until the next completion
//   frame_error  : stop bit sampled low on the last completed frame
//   parity_error : even-parity mismatch on the last completed frame
//                  (only when UART_RX_PARITY_EN is defined)
// Optional feature macro: UART_RX_PARITY_EN.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             rx,
  input  logic             tick,
  output logic             data_ready,
  output logic [DBITS-1:0] data_out,
  output logic             frame_error
`ifdef UART_RX_PARITY_EN
  ,
  output logic             parity_error
`endif
);
  localparam int NW = $clog2(DBITS);

  logic             rx_s;
  state_t           state, state_next;
  logic [4:0]       s, s_next;
  logic [NW-1:0]    n, n_next;
  logic [DBITS-1:0] b, b_next;
  logic [DBITS-1:0] dout_next;
  logic             fe_next, rdy_next;
`ifdef UART_RX_PARITY_EN
  logic             par_bit, par_next, pe_next;
`endif

  sync_2ff u_sync (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .d          (rx),
    .q          (rx_s)
  );

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state       <= IDLE;
      s           <= '0;
      n           <= '0;
      b           <= '0;
      data_out    <= '0;
      data_ready  <= 1'b0;
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      s           <= s_next;
      n           <= n_next;
      b           <= b_next;
      data_out    <= dout_next;
      data_ready  <= rdy_next;
      frame_error <= fe_next;
`ifdef UART_RX_PARITY_EN
      par_bit      <= par_next;
      parity_error <= pe_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    dout_next  = data_out;
    fe_next    = frame_error;
    rdy_next   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_next   = par_bit;
    pe_next    = parity_error;
`endif
    case (state)
      // tick is deliberately ignored here; counting starts in START
      IDLE: if (!rx_s) begin
        s_next     = '0;
        state_next = START;
      end
      START: if (tick) begin
        if (s == 5'(MID_START)) begin
          if (!rx_s) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            state_next = IDLE;  // false start: line went back high
          end
        end else begin
          s_next = s + 5'd1;
        end
      end
      DATA: if (tick) begin
        if (s == 5'(BIT_TICKS - 1)) begin
          s_next = '0;
          b_next = {rx_s, b[DBITS-1:1]};
          if (n == NW'(DBITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            n_next = n + NW'(1);
          end
        end else begin
          s_next = s + 5'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        if (s == 5'(BIT_TICKS - 1)) begin
          s_next     = '0;
          par_next   = rx_s;
          state_next = STOP;
        end else begin
          s_next = s + 5'd1;
        end
      end
`endif
      STOP: if (tick) begin
        if (s == 5'(SB_TICK - 1)) begin
          dout_next  = b;
          fe_next    = ~rx_s;
          rdy_next   = 1'b1;
`ifdef UART_RX_PARITY_EN
          pe_next    = (^b) ^ par_bit;
`endif
          state_next = IDLE;
        end else begin
          s_next = s + 5'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench. Each frame driven onto rx pushes its
// expected word/flags (computed from the frame contents) into a queue; a
// monitor pops and compares on every data_ready pulse.
module tb_uart_receiver;
  localparam int DBITS   = 8;
  localparam int SB_TICK = 16;

  logic       clk_100MHz = 1'b0;
  logic       reset      = 1'b1;
  logic       rx         = 1'b1;
  logic       tick       = 1'b0;
  logic       data_ready;
  logic [7:0] data_out;
  logic       frame_error;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif

  uart_receiver #(.DBITS(DBITS), .SB_TICK(SB_TICK)) dut (
    .clk_100MHz  (clk_100MHz),
    .reset       (reset),
    .rx          (rx),
    .tick        (tick),
    .data_ready  (data_ready),
    .data_out    (data_out),
    .frame_error (frame_error)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_error(parity_error)
`endif
  );

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t       q[$];
  int         chk_cnt = 0;
  int         pass_cnt = 0;
  int         pulses = 0;
  int         sent = 0;
  logic [7:0] last_d = 8'h00;
  logic       prev_rdy = 1'b0;
  int         tcnt = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  // tick high for one clock out of every four
  always @(negedge clk_100MHz) begin
    tcnt = (tcnt + 1) % 4;
    tick = (tcnt == 0);
  end

  task automatic check(input string nm, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
  endtask

  // monitor: pop and compare on every completion pulse
  always @(negedge clk_100MHz) begin
    if (data_ready) begin
      exp_t e;
      pulses++;
      check("ready_one_cycle", int'(prev_rdy), 0);
      if (q.size() == 0) begin
        check("unexpected_ready", 1, 0);
      end else begin
        e = q.pop_front();
        check("data_out", int'(data_out), int'(e.d));
        check("frame_error", int'(frame_error), int'(e.fe));
`ifdef UART_RX_PARITY_EN
        check("parity_error", int'(parity_error), int'(e.pe));
`endif
        last_d = e.d;
      end
    end
    prev_rdy = data_ready;
  end

  task automatic wait_ticks(input int k);
    repeat (k) begin
      @(posedge clk_100MHz);
      while (!tick) @(posedge clk_100MHz);
    end
    @(negedge clk_100MHz);
  endtask

  task automatic drive_bit(input logic v, input int k);
    rx = v;
    wait_ticks(k);
  endtask

  // stop_ok=0 drives the stop bit low long enough to be sampled, then
  // releases the line; par_bad flips the even-parity bit.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                            input bit par_bad, input int gap);
    exp_t e;
    logic pbit;
    int   g;
    pbit = logic'(($countones(d) % 2) != 0) ^ par_bad;
    e.d  = d;
    e.fe = !stop_ok;
`ifdef UART_RX_PARITY_EN
    e.pe = logic'((($countones(d) + int'(pbit)) % 2) != 0);
`else
    e.pe = 1'b0;
`endif
    check("data_out_held", int'(data_out), int'(last_d));
    q.push_back(e);
    sent++;
    drive_bit(1'b0, 16);
    for (int i = 0; i < DBITS; i++) drive_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
    drive_bit(pbit, 16);
`endif
    if (stop_ok) begin
      drive_bit(1'b1, SB_TICK);
    end else begin
      drive_bit(1'b0, 9);
      drive_bit(1'b1, SB_TICK - 9);
    end
    g = (!stop_ok && gap < 4) ? 4 : gap;
    if (g > 0) drive_bit(1'b1, g);
  endtask

  initial begin
    int p0;
    int budget;
    repeat (3) @(negedge clk_100MHz);
    check("reset_data_out", int'(data_out), 0);
    check("reset_data_ready", int'(data_ready), 0);
    check("reset_frame_error", int'(frame_error), 0);
`ifdef UART_RX_PARITY_EN
    check("reset_parity_error", int'(parity_error), 0);
`endif
    reset = 1'b0;
    wait_ticks(20);

    send_frame(8'h55, 1'b1, 1'b0, 4);

    // false start: low for 4 ticks only
    p0 = pulses;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 40);
    check("glitch_no_ready", pulses, p0);

    send_frame(8'h00, 1'b0, 1'b0, 4);

    // reset after 3 data bits of 0xA3 abandons the frame
    p0 = pulses;
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 16);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk_100MHz);
    reset = 1'b0;
    last_d = 8'h00;
    wait_ticks(40);
    check("reset_abort_no_ready", pulses, p0);
    check("reset_abort_data_out", int'(data_out), 0);
    send_frame(8'hA3, 1'b1, 1'b0, 0);

    // back-to-back, no idle gap
    send_frame(8'h01, 1'b1, 1'b0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 2);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 2);
    send_frame(8'h07, 1'b1, 1'b0, 2);
`endif

    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      bit ok;
      d  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(d, ok, bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    budget = 0;
    while (q.size() != 0 && budget < 2000) begin
      @(negedge clk_100MHz);
      budget++;
    end
    check("queue_drained", q.size(), 0);
    check("pulse_count", pulses, sent);
    check("final_data_out", int'(data_out), int'(last_d));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
